hdb3_decode: RTL and testbench
==============================

HDB3_DECODE -- requirements
Module: hdb3_decode

Interface
REQ-001 Parameter CNT_W, default 16: width of the error counter.
REQ-002 clk  input  1  symbol clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 sym_en  input  1  symbol strobe; the in_p/in_n symbol is accepted only on cycles where sym_en=1.
REQ-005 in_p  input  1  positive-pulse rail.
REQ-006 in_n  input  1  negative-pulse rail.
REQ-007 dout  output  1  decoded NRZ bit.
REQ-008 dout_vld  output  1  one-cycle strobe marking dout valid.
REQ-009 err_rail  output  1  one-cycle flag: in_p=in_n=1 accepted.
REQ-010 err_zeros  output  1  one-cycle flag: fourth consecutive zero accepted.
REQ-011 err_vpol  output  1  one-cycle flag: V with the same polarity as the previous V.
REQ-012 err_cnt  output  CNT_W  saturating count of all error events.

Function
REQ-013 Symbol mapping: p=1,n=0 is +pulse; p=0,n=1 is -pulse; 00 is zero; 11 is a rail error and decodes as zero.
REQ-014 last_pol holds the polarity of the last accepted pulse (NONE/POS/NEG); it updates on every pulse.
REQ-015 A pulse whose polarity differs from last_pol, or any pulse while last_pol=NONE, is a mark and enters the delay line as 1.
REQ-016 A pulse whose polarity equals last_pol is V. It enters as 0 and forces the 3 most recent delay-line entries to 0, which removes B in B00V.
REQ-017 The delay line is 4 entries deep and shifts only on sym_en=1.
REQ-018 dout is the entry shifted out, registered. dout_vld=1 on the cycle after an accepting sym_en once 4 symbols have been accepted since reset; otherwise dout_vld=0.
REQ-019 Latency: the bit for the symbol accepted at edge k appears on dout with dout_vld after the 4th subsequent accepting edge.
REQ-020 sym_en=0 holds all state, and dout_vld=0 on the following cycle.
REQ-021 last_v_pol records the polarity of the last V and drives err_vpol; it starts as NONE, and the first V never flags.
REQ-022 zero_run counts consecutive accepted zeros (including rail errors), saturating at 4; err_zeros pulses when it reaches 4.
REQ-023 Simultaneous errors on one symbol increment err_cnt by 1 per asserted flag; err_cnt holds at all-ones.

Reset
REQ-024 With rst=1 at a clock edge:
- dout=0, dout_vld=0, all err_* flags=0, err_cnt=0;
- delay line cleared to zero;
- fill count=0;
- last_pol=NONE, last_v_pol=NONE, zero_run=0.
REQ-025 Reset asserted mid-stream discards all in-flight bits; no dout_vld is produced for them.

Configuration
REQ-026 Macro HDB3_DEC_ERR_EN defined: err_rail, err_zeros, err_vpol, err_cnt, last_v_pol and zero_run are implemented as specified.
REQ-027 HDB3_DEC_ERR_EN undefined: the error ports remain, tied to 0; decoding is unchanged, including 11 decoding as zero.

Structure
REQ-028 Shared package hdb3_pkg holds:
- symbol codes HDB3_0=2'b00, HDB3_1=2'b01, HDB3_V=2'b11, HDB3_B=2'b10;
- polarity enum NONE/POS/NEG;
- delay depth constant 4.
REQ-029 Sub-module hdb3_dec_dline implements the 4-deep shift line with enable and a 3-entry clear.

Verification
REQ-030 After reset, pulses +,0,0,0,+,- (sym_en=1 every cycle) -> dout 1,0,0,0,0,1, with the first dout_vld 4 cycles after the first symbol.
REQ-031 Pulses +,-,0,0,-,+ (B00V) -> dout 1,0,0,0,0,1; no error flags.
REQ-032 Symbol 11 inside a stream -> dout=0 for that slot, err_rail=1 for one cycle, err_cnt=1.
REQ-033 Symbols 0,0,0,0 after a pulse -> err_zeros on the 4th zero; err_cnt increments by 1.
REQ-034 Two V of the same polarity, i.e. +,0,0,0,+,0,0,0,+ -> err_vpol=1 on the second V.
REQ-035 sym_en toggled 1,0,1,0 mid-stream -> output sequence identical to continuous sym_en; rst asserted mid-stream -> dout_vld=0 until 4 new symbols are accepted; err_cnt forced near saturation -> holds at all-ones.

Source files
------------

// File: rtl/hdb3_pkg.sv
// Shared HDB3 decoder definitions: symbol classes, pulse polarity and delay depth.
package hdb3_pkg;

    localparam logic [1:0] HDB3_0 = 2'b00;
    localparam logic [1:0] HDB3_1 = 2'b01;
    localparam logic [1:0] HDB3_V = 2'b11;
    localparam logic [1:0] HDB3_B = 2'b10;

    localparam int HDB3_DEPTH = 4;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        POS  = 2'd1,
        NEG  = 2'd2
    } pol_t;

endpackage

// File: rtl/hdb3_dec_dline.sv
// Four-deep decode delay line; a V clears the three youngest entries as it shifts in.
module hdb3_dec_dline
    import hdb3_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr3,
    input  logic din,
    output logic tap
);

    logic [HDB3_DEPTH-1:0] line;
    logic [HDB3_DEPTH-2:0] keep;

    // Entries that survive the shift; zeroed when the incoming symbol is a V.
    assign keep = clr3 ? '0 : line[HDB3_DEPTH-2:0];
    assign tap  = line[HDB3_DEPTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            line <= '0;
        end else if (en) begin
            line <= {keep, din};
        end
    end

endmodule

// File: rtl/hdb3_decode.sv
// HDB3 line decoder with optional error detection, enabled by defining HDB3_DEC_ERR_EN.
module hdb3_decode
    import hdb3_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sym_en,
    input  logic             in_p,
    input  logic             in_n,
    output logic             dout,
    output logic             dout_vld,
    output logic             err_rail,
    output logic             err_zeros,
    output logic             err_vpol,
    output logic [CNT_W-1:0] err_cnt
);

    logic       is_pulse;
    logic       is_v;
    logic       bit_in;
    logic       line_out;
    logic [1:0] sym_cls;
    logic [2:0] fill;
    pol_t       cur_pol;
    pol_t       last_pol;

    assign is_pulse = in_p ^ in_n;
    assign cur_pol  = in_p ? POS : NEG;
    assign is_v     = is_pulse && (cur_pol == last_pol);
    assign sym_cls  = !is_pulse ? HDB3_0 : (is_v ? HDB3_V : HDB3_1);
    assign bit_in   = (sym_cls == HDB3_1);

    hdb3_dec_dline u_dline (
        .clk  (clk),
        .rst  (rst),
        .en   (sym_en),
        .clr3 (is_v),
        .din  (bit_in),
        .tap  (line_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            dout     <= 1'b0;
            dout_vld <= 1'b0;
            fill     <= '0;
            last_pol <= NONE;
        end else begin
            dout_vld <= 1'b0;
            if (sym_en) begin
                dout <= line_out;
                // Output is valid only once the line holds real symbols end to end.
                if (fill == 3'(HDB3_DEPTH)) begin
                    dout_vld <= 1'b1;
                end else begin
                    fill <= fill + 3'd1;
                end
                if (is_pulse) begin
                    last_pol <= cur_pol;
                end
            end
        end
    end

`ifdef HDB3_DEC_ERR_EN
    pol_t         last_v_pol;
    logic [2:0]   zero_run;
    logic         f_rail;
    logic         f_zeros;
    logic         f_vpol;
    logic [CNT_W:0] cnt_sum;

    assign f_rail  = in_p & in_n;
    assign f_zeros = !is_pulse && (zero_run == 3'd3);
    assign f_vpol  = is_v && (last_v_pol == cur_pol);
    assign cnt_sum = {1'b0, err_cnt} + (CNT_W+1)'(f_rail) + (CNT_W+1)'(f_zeros)
                   + (CNT_W+1)'(f_vpol);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_rail   <= 1'b0;
            err_zeros  <= 1'b0;
            err_vpol   <= 1'b0;
            err_cnt    <= '0;
            last_v_pol <= NONE;
            zero_run   <= '0;
        end else begin
            err_rail  <= 1'b0;
            err_zeros <= 1'b0;
            err_vpol  <= 1'b0;
            if (sym_en) begin
                err_rail  <= f_rail;
                err_zeros <= f_zeros;
                err_vpol  <= f_vpol;
                err_cnt   <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
                if (is_pulse) begin
                    zero_run <= '0;
                end else if (zero_run != 3'd4) begin
                    zero_run <= zero_run + 3'd1;
                end
                if (is_v) begin
                    last_v_pol <= cur_pol;
                end
            end
        end
    end
`else
    assign err_rail  = 1'b0;
    assign err_zeros = 1'b0;
    assign err_vpol  = 1'b0;
    assign err_cnt   = '0;
`endif

endmodule

// File: tb/tb_hdb3_decode.sv
// Self-checking bench for hdb3_decode against a symbol-history reference model.
module tb_hdb3_decode;

    localparam int CNT_W = 4;
    localparam int CMAX  = 15;
`ifdef HDB3_DEC_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, sym_en, in_p, in_n;
    logic dout, dout_vld, err_rail, err_zeros, err_vpol;
    logic [CNT_W-1:0] err_cnt;

    hdb3_decode #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .sym_en    (sym_en),
        .in_p      (in_p),
        .in_n      (in_n),
        .dout      (dout),
        .dout_vld  (dout_vld),
        .err_rail  (err_rail),
        .err_zeros (err_zeros),
        .err_vpol  (err_vpol),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: every accepted symbol's decoded bit, indexed from reset.
    int bits[$];
    int m_last, m_lastv, m_zr, m_cnt;
    logic e_vld, e_dout, e_rail, e_zeros, e_vpol;
    logic [CNT_W-1:0] e_cnt;
    logic [0:0] exp_q[$];

    task automatic model_reset();
        bits.delete();
        m_last = 0; m_lastv = 0; m_zr = 0; m_cnt = 0;
        e_vld = 0; e_dout = 0; e_rail = 0; e_zeros = 0; e_vpol = 0; e_cnt = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1; sym_en = 1'b0; in_p = 1'b0; in_n = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Symbol codes for stimulus: 0 zero, 1 +pulse, 2 -pulse, 3 rail error.
    task automatic send(input logic en, input int s);
        int idx, pol, b;
        logic p, n;
        p = (s == 1 || s == 3);
        n = (s == 2 || s == 3);
        sym_en = en; in_p = p; in_n = n;
        @(posedge clk); #1;
        sym_en = 1'b0;
        e_vld = 0; e_dout = 0; e_rail = 0; e_zeros = 0; e_vpol = 0;
        if (en) begin
            idx = bits.size();
            pol = p ? 1 : 2;
            e_rail = p & n;
            if (p ^ n) begin
                m_zr = 0;
                if (m_last == pol) begin
                    e_vpol = (m_lastv == pol);
                    m_lastv = pol;
                    b = 0;
                    for (int k = 1; k <= 3; k++) if (idx - k >= 0) bits[idx-k] = 0;
                end else begin
                    b = 1;
                end
                m_last = pol;
            end else begin
                b = 0;
                if (m_zr == 3) e_zeros = 1;
                if (m_zr < 4) m_zr++;
            end
            bits.push_back(b);
            e_vld = (idx >= 4);
            if (e_vld) e_dout = bits[idx-4][0];
            m_cnt = m_cnt + int'(e_rail) + int'(e_zeros) + int'(e_vpol);
            if (m_cnt > CMAX) m_cnt = CMAX;
        end
        if (!ERR_EN) begin
            e_rail = 0; e_zeros = 0; e_vpol = 0;
        end
        e_cnt = ERR_EN ? CNT_W'(m_cnt) : '0;
    endtask

    task automatic test_reset();
        send(1, 1); send(1, 3); send(1, 2);
        do_reset();
        checks++;
        if ({dout, dout_vld, err_rail, err_zeros, err_vpol, err_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got dout=%b vld=%b rail=%b zeros=%b vpol=%b cnt=%0d want all zero",
                     dout, dout_vld, err_rail, err_zeros, err_vpol, err_cnt);
        end
    endtask

    task automatic test_directed();
        int seq[5][9] = '{'{1,0,0,0,1,2,0,0,0}, '{1,2,0,0,2,1,0,0,0}, '{1,2,3,1,2,1,0,0,0},
                          '{1,0,0,0,0,2,0,0,0}, '{1,0,0,0,1,0,0,0,1}};
        int ex[5][9]  = '{'{1,0,0,0,0,1,0,0,0}, '{1,0,0,0,0,1,0,0,0}, '{1,1,0,1,1,1,0,0,0},
                          '{1,0,0,0,0,1,0,0,0}, '{1,0,0,0,0,0,0,0,0}};
        int len[5]  = '{6, 6, 6, 6, 9};
        int ecnt[5] = '{0, 0, 1, 1, 1};
        int first_vld;
        for (int t = 0; t < 5; t++) begin
            do_reset();
            exp_q.delete();
            for (int i = 0; i < len[t]; i++) exp_q.push_back(1'(ex[t][i]));
            first_vld = -1;
            for (int i = 0; i < len[t] + 4; i++) begin
                send(1, (i < len[t]) ? seq[t][i] : 0);
                checks++;
                if ({dout_vld, dout_vld & dout, err_rail, err_zeros, err_vpol, err_cnt} !==
                    {e_vld, e_vld & e_dout, e_rail, e_zeros, e_vpol, e_cnt}) begin
                    failures++;
                    $display("FAIL directed%0d_sym%0d got vld=%b d=%b r=%b z=%b v=%b c=%0d want vld=%b d=%b r=%b z=%b v=%b c=%0d",
                             t, i, dout_vld, dout, err_rail, err_zeros, err_vpol, err_cnt,
                             e_vld, e_dout, e_rail, e_zeros, e_vpol, e_cnt);
                end
                if (dout_vld === 1'b1) begin
                    if (first_vld < 0) first_vld = i;
                    checks++;
                    if (exp_q.size() == 0 || dout !== exp_q[0]) begin
                        failures++;
                        $display("FAIL directed%0d_bit got dout=%b want %b", t, dout,
                                 (exp_q.size() == 0) ? 1'bx : exp_q[0]);
                    end
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end
                if (i == len[t] - 1) begin
                    checks++;
                    if (err_cnt !== (ERR_EN ? CNT_W'(ecnt[t]) : '0)) begin
                        failures++;
                        $display("FAIL directed%0d_errcnt got %0d want %0d", t, err_cnt,
                                 ERR_EN ? ecnt[t] : 0);
                    end
                end
            end
            checks++;
            if (first_vld != 4 || exp_q.size() != 0) begin
                failures++;
                $display("FAIL directed%0d_latency got first_vld=%0d left=%0d want 4 and 0",
                         t, first_vld, exp_q.size());
            end
        end
    endtask

    task automatic test_sym_en_gaps();
        int seq[6] = '{1, 0, 0, 0, 1, 2};
        int ex[6]  = '{1, 0, 0, 0, 0, 1};
        do_reset();
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back(1'(ex[i]));
        for (int i = 0; i < 20; i++) begin
            send((i % 2) == 0, (i / 2 < 6) ? seq[i/2] : 0);
            checks++;
            if ({dout_vld, dout_vld & dout, err_rail, err_zeros, err_vpol, err_cnt} !==
                {e_vld, e_vld & e_dout, e_rail, e_zeros, e_vpol, e_cnt}) begin
                failures++;
                $display("FAIL gaps_cyc%0d got vld=%b d=%b c=%0d want vld=%b d=%b c=%0d",
                         i, dout_vld, dout, err_cnt, e_vld, e_dout, e_cnt);
            end
            if (dout_vld === 1'b1) begin
                checks++;
                if (exp_q.size() == 0 || dout !== exp_q[0]) begin
                    failures++;
                    $display("FAIL gaps_bit got dout=%b want %b", dout,
                             (exp_q.size() == 0) ? 1'bx : exp_q[0]);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL gaps_drain got %0d bits left want 0", exp_q.size());
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 6; i++) send(1, (i % 2) ? 2 : 1);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(1, (i % 2) ? 1 : 2);
            checks++;
            if (dout_vld !== (i == 4) || (dout_vld === 1'b1 && dout !== e_dout)) begin
                failures++;
                $display("FAIL midreset_sym%0d got vld=%b d=%b want vld=%b d=%b",
                         i, dout_vld, dout, (i == 4), e_dout);
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            send(1, 3);
            checks++;
            if ({dout_vld, dout_vld & dout, err_rail, err_zeros, err_vpol, err_cnt} !==
                {e_vld, e_vld & e_dout, e_rail, e_zeros, e_vpol, e_cnt}) begin
                failures++;
                $display("FAIL sat_sym%0d got r=%b z=%b c=%0d want r=%b z=%b c=%0d",
                         i, err_rail, err_zeros, err_cnt, e_rail, e_zeros, e_cnt);
            end
        end
        checks++;
        if (err_cnt !== (ERR_EN ? 4'hF : 4'h0)) begin
            failures++;
            $display("FAIL sat_hold got %0d want %0d", err_cnt, ERR_EN ? 15 : 0);
        end
    endtask

    task automatic test_random();
        int r, s;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            s = (r < 4) ? 0 : (r < 7) ? 1 : (r < 9) ? 2 : 3;
            send($urandom_range(0, 3) != 0, s);
            checks++;
            if ({dout_vld, dout_vld & dout, err_rail, err_zeros, err_vpol, err_cnt} !==
                {e_vld, e_vld & e_dout, e_rail, e_zeros, e_vpol, e_cnt}) begin
                failures++;
                $display("FAIL random_cyc%0d got vld=%b d=%b r=%b z=%b v=%b c=%0d want vld=%b d=%b r=%b z=%b v=%b c=%0d",
                         i, dout_vld, dout, err_rail, err_zeros, err_vpol, err_cnt,
                         e_vld, e_dout, e_rail, e_zeros, e_vpol, e_cnt);
            end
        end
    endtask

    initial begin
        rst = 1'b1; sym_en = 1'b0; in_p = 1'b0; in_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_directed();
        test_sym_en_gaps();
        test_mid_reset();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
